// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'd0,
        OP_XOR = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } alu_op_t;

    // True for operations that use the carry chain.
    function automatic logic is_arith(alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-issue / result-writeback handshake bundle for alu_pipe.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 64
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    alu_op_t          op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, s, cout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, s, cout, zero, neg, ovf
    );

endinterface

// File: rtl/alu_seg.sv
// Combinational SEG-bit ALU slice: a ripple chain of one-bit ALU cells.
module alu_seg
    import alu_pkg::*;
#(
    parameter int unsigned SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    input  alu_op_t        op,
    output logic [SEG-1:0] s,
    output logic           cout
);

    // Bit-cell ripple; SUB inverts b, the caller supplies the +1 via cin.
    always_comb begin
        logic c;
        logic bi;
        s  = '0;
        c  = cin;
        bi = 1'b0;
        for (int i = 0; i < SEG; i++) begin
            bi = (op == OP_SUB) ? ~b[i] : b[i];
            case (op)
                OP_NOR:  s[i] = ~(a[i] | b[i]);
                OP_XOR:  s[i] = a[i] ^ b[i];
                OP_ADD,
                OP_SUB:  s[i] = a[i] ^ bi ^ c;
                default: s[i] = 1'b0;
            endcase
            c = (a[i] & bi) | (c & (a[i] ^ bi));
        end
        cout = is_arith(op) & c;
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined NOR/XOR/ADD/SUB ALU: the carry chain is cut into STAGES
// segments, one register stage each, under a valid/ready handshake.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;
    localparam int unsigned MSB  = WIDTH - 1;

    if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("alu_pipe: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end

    // Per-stage registers: valid, op, skewed operands, de-skewed result, carry.
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    alu_op_t          op_q  [STAGES];
    alu_op_t          op_d  [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic [WIDTH-1:0] res_d [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];
    logic             zero_q, zero_d;
    logic             neg_q,  neg_d;
    logic             ovf_q,  ovf_d;

    // What each stage sees this cycle (previous stage's registers or the bus).
    logic             stg_vld [STAGES];
    alu_op_t          stg_op  [STAGES];
    logic [WIDTH-1:0] stg_a   [STAGES];
    logic [WIDTH-1:0] stg_b   [STAGES];
    logic [WIDTH-1:0] stg_res [STAGES];
    logic             stg_cy  [STAGES];
    logic [SEG-1:0]   seg_s   [STAGES];
    logic             seg_cy  [STAGES];

    logic stall_c;
    logic accept_c;

    // Global stall: a result is waiting and downstream is not taking it.
    assign stall_c      = vld_q[LAST] & ~bus.out_ready;
    assign bus.in_ready = ~rst & ~stall_c;
    assign accept_c     = bus.in_valid & bus.in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stg_vld[k] = accept_c;
            assign stg_op[k]  = bus.op;
            assign stg_a[k]   = bus.a;
            assign stg_b[k]   = bus.b;
            assign stg_res[k] = '0;
            assign stg_cy[k]  = bus.cin;
        end else begin : g_next
            assign stg_vld[k] = vld_q[k-1];
            assign stg_op[k]  = op_q[k-1];
            assign stg_a[k]   = a_q[k-1];
            assign stg_b[k]   = b_q[k-1];
            assign stg_res[k] = res_q[k-1];
            assign stg_cy[k]  = cy_q[k-1];
        end

        alu_seg #(.SEG(SEG)) u_seg (
            .a    (stg_a[k][k*SEG +: SEG]),
            .b    (stg_b[k][k*SEG +: SEG]),
            .cin  (stg_cy[k]),
            .op   (stg_op[k]),
            .s    (seg_s[k]),
            .cout (seg_cy[k])
        );
    end

    // Advance every stage together unless stalled; flags form in the last stage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = vld_q[k];
            op_d[k]  = op_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            res_d[k] = res_q[k];
            cy_d[k]  = cy_q[k];
        end
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (!stall_c) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k]                  = stg_vld[k];
                op_d[k]                   = stg_op[k];
                a_d[k]                    = stg_a[k];
                b_d[k]                    = stg_b[k];
                res_d[k]                  = stg_res[k];
                res_d[k][k*SEG +: SEG]    = seg_s[k];
                cy_d[k]                   = seg_cy[k];
            end
            zero_d = (res_d[LAST] == '0);
            neg_d  = res_d[LAST][MSB];
            case (stg_op[LAST])
                OP_ADD:  ovf_d = (stg_a[LAST][MSB] == stg_b[LAST][MSB]) &&
                                 (res_d[LAST][MSB] != stg_a[LAST][MSB]);
                OP_SUB:  ovf_d = (stg_a[LAST][MSB] != stg_b[LAST][MSB]) &&
                                 (res_d[LAST][MSB] != stg_a[LAST][MSB]);
                default: ovf_d = 1'b0;
            endcase
        end
    end

    // Stage registers; reset flushes every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                op_q[k]  <= OP_NOR;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
                cy_q[k]  <= 1'b0;
            end
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                op_q[k]  <= op_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                res_q[k] <= res_d[k];
                cy_q[k]  <= cy_d[k];
            end
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_valid = vld_q[LAST];
    assign bus.s         = res_q[LAST];
    assign bus.cout      = cy_q[LAST];
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, backpressure and mid-stream
// reset on a 64/4 instance, plus random sweeps on 64/1, 64/2, 64/8, 16/4.
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct packed {
        alu_op_t     op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        cout;
        logic        zero;
        logic        neg;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [67:0] r;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic rst_sw;
    logic sweep_go;
    int   sweep_done_cnt;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(64)) bus0 ();
    alu_pipe #(.WIDTH(64), .STAGES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference: plain modular arithmetic on w-bit values; returns {ovf,neg,zero,cout,s}.
    function automatic logic [67:0] ref_alu(int unsigned w, logic [1:0] op,
                                            logic [63:0] a, logic [63:0] b, logic cin);
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] s;
        logic [64:0] full;
        logic [5:0]  msb;
        logic [6:0]  wi;
        logic        c;
        logic        v;
        msb  = 6'(w - 1);
        wi   = 7'(w);
        mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        a    = a & mask;
        b    = b & mask;
        c    = 1'b0;
        v    = 1'b0;
        s    = '0;
        case (op)
            2'd0: s = ~(a | b) & mask;
            2'd1: s = (a ^ b) & mask;
            default: begin
                bb   = (op == 2'd3) ? (~b & mask) : b;
                full = {1'b0, a} + {1'b0, bb} + 65'(cin);
                s    = full[63:0] & mask;
                c    = full[wi];
                if (op == 2'd2) v = (a[msb] == b[msb]) && (s[msb] != a[msb]);
                else            v = (a[msb] != b[msb]) && (s[msb] != a[msb]);
            end
        endcase
        return {v, s[msb], (s == 64'd0), c, s};
    endfunction

    // Issue one directed vector and check result, flags and latency.
    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic seen;
        @(negedge clk);
        bus0.op        = v.op;
        bus0.a         = v.a;
        bus0.b         = v.b;
        bus0.cin       = v.cin;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), 128'(bus0.in_ready), 128'(1'b1));
        @(negedge clk);
        bus0.in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (lat <= 20) begin
            if (bus0.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), 128'(seen ? lat : 999), 128'(4));
        check($sformatf("vec%0d_s", idx),    128'(bus0.s),    128'(v.s));
        check($sformatf("vec%0d_cout", idx), 128'(bus0.cout), 128'(v.cout));
        check($sformatf("vec%0d_zero", idx), 128'(bus0.zero), 128'(v.zero));
        check($sformatf("vec%0d_neg", idx),  128'(bus0.neg),  128'(v.neg));
        check($sformatf("vec%0d_ovf", idx),  128'(bus0.ovf),  128'(v.ovf));
    endtask

    // Random sweeps with the reference model on other configurations.
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned SW = (g == 3) ? 16 : 64;
        localparam int unsigned SS = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 4;

        alu_pipe_if #(.WIDTH(SW)) sbus ();
        alu_pipe #(.WIDTH(SW), .STAGES(SS)) u_dut (
            .clk (clk),
            .rst (rst_sw),
            .bus (sbus)
        );

        initial begin
            exp_t        q[$];
            exp_t        e;
            int unsigned ncyc;
            int          issued;
            int          got;
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rc;
            logic [1:0]  rop;
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b1;
            sbus.a         = '0;
            sbus.b         = '0;
            sbus.cin       = 1'b0;
            sbus.op        = OP_NOR;
            wait (sweep_go);
            ncyc   = 0;
            issued = 0;
            got    = 0;
            while (got < 1000 && ncyc < 5000) begin
                @(negedge clk);
                ncyc++;
                if (sbus.out_valid) begin
                    if (q.size() == 0) begin
                        check($sformatf("sweep%0d_spurious", g), 128'(1), 128'(0));
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sweep%0d_result", g),
                              128'({sbus.ovf, sbus.neg, sbus.zero, sbus.cout, 64'(sbus.s)}),
                              128'(e.r));
                        check($sformatf("sweep%0d_latency", g), 128'(ncyc - e.cyc), 128'(SS));
                    end
                    got++;
                end
                if (issued < 1000 && $urandom_range(3) != 0) begin
                    ra  = {$urandom, $urandom};
                    rb  = {$urandom, $urandom};
                    if ($urandom_range(7) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
                    if ($urandom_range(7) == 0) rb = 64'd1;
                    rc  = 1'($urandom_range(1));
                    rop = 2'($urandom_range(3));
                    sbus.a        = SW'(ra);
                    sbus.b        = SW'(rb);
                    sbus.cin      = rc;
                    sbus.op       = alu_op_t'(rop);
                    sbus.in_valid = 1'b1;
                    if (sbus.in_ready) begin
                        e.r   = ref_alu(SW, rop, ra, rb, rc);
                        e.cyc = ncyc;
                        q.push_back(e);
                        issued++;
                    end
                end else begin
                    sbus.in_valid = 1'b0;
                end
            end
            sbus.in_valid = 1'b0;
            check($sformatf("sweep%0d_count", g), 128'(got), 128'(1000));
            sweep_done_cnt++;
        end
    end

    initial begin
        vec_t        vecs[11];
        exp_t        q[$];
        exp_t        e;
        logic [63:0] pa[10];
        logic [63:0] pb[10];
        logic        pc[10];
        logic [1:0]  pop[10];
        int          issued;
        int          got;
        int          c;
        int          lat;
        logic        seen;

        vecs[0]  = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0,                  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{OP_SUB, 64'd5, 64'd7, 1'b1,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{OP_NOR, 64'd0, 64'd0, 1'b0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{OP_XOR, 64'h1234, 64'h1234, 1'b0,            64'd0,                  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_SUB, 64'd7, 64'd5, 1'b1,                  64'd2,                  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{OP_ADD, 64'd0, 64'd0, 1'b1,                  64'd1,                  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_NOR, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};

        n_checks       = 0;
        n_fail         = 0;
        sweep_done_cnt = 0;
        sweep_go       = 1'b0;
        rst            = 1'b1;
        rst_sw         = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.cin       = 1'b0;
        bus0.op        = OP_NOR;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state, still inside reset.
        check("rst_out_valid", 128'(bus0.out_valid), 128'(0));
        check("rst_s",         128'(bus0.s),         128'(0));
        check("rst_flags",     128'({bus0.cout, bus0.zero, bus0.neg, bus0.ovf}), 128'(0));
        check("rst_in_ready",  128'(bus0.in_ready),  128'(0));
        rst    = 1'b0;
        rst_sw = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(bus0.in_ready), 128'(1));

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Backpressure: 10 back-to-back beats, out_ready low on cycles 6..8.
        for (int i = 0; i < 10; i++) begin
            pa[i]  = {$urandom, $urandom};
            pb[i]  = {$urandom, $urandom};
            pc[i]  = 1'($urandom_range(1));
            pop[i] = 2'($urandom_range(3));
        end
        issued = 0;
        got    = 0;
        c      = 0;
        while (got < 10 && c < 60) begin
            @(negedge clk);
            bus0.out_ready = !(c >= 6 && c <= 8);
            #1;
            check("bp_in_ready", 128'(bus0.in_ready),
                  128'(!(bus0.out_valid && !bus0.out_ready)));
            if (bus0.out_valid && bus0.out_ready) begin
                if (q.size() == 0) begin
                    check("bp_extra_beat", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    check($sformatf("bp_result%0d", got),
                          128'({bus0.ovf, bus0.neg, bus0.zero, bus0.cout, bus0.s}), 128'(e.r));
                end
                got++;
            end
            if (issued < 10) begin
                bus0.a        = pa[issued];
                bus0.b        = pb[issued];
                bus0.cin      = pc[issued];
                bus0.op       = alu_op_t'(pop[issued]);
                bus0.in_valid = 1'b1;
                if (bus0.in_ready) begin
                    e.r   = ref_alu(64, pop[issued], pa[issued], pb[issued], pc[issued]);
                    e.cyc = 0;
                    q.push_back(e);
                    issued++;
                end
            end else begin
                bus0.in_valid = 1'b0;
            end
            c++;
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        check("bp_count", 128'(got), 128'(10));
        repeat (6) @(negedge clk);
        check("bp_no_extra", 128'(bus0.out_valid), 128'(0));

        // Reset mid-stream with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus0.op       = OP_ADD;
            bus0.a        = 64'h1111 * 64'(i + 1);
            bus0.b        = 64'd3;
            bus0.cin      = 1'b0;
            bus0.in_valid = 1'b1;
        end
        @(negedge clk);
        bus0.in_valid = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 128'(bus0.out_valid), 128'(0));
        check("midrst_s",         128'(bus0.s),         128'(0));
        check("midrst_flags",     128'({bus0.cout, bus0.zero, bus0.neg, bus0.ovf}), 128'(0));
        check("midrst_in_ready",  128'(bus0.in_ready),  128'(0));
        rst           = 1'b0;
        bus0.op       = OP_ADD;
        bus0.a        = 64'd10;
        bus0.b        = 64'd20;
        bus0.cin      = 1'b0;
        bus0.in_valid = 1'b1;
        #1;
        check("midrst_first_accept", 128'(bus0.in_ready), 128'(1));
        @(negedge clk);
        bus0.in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (lat <= 20) begin
            if (bus0.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check("midrst_latency", 128'(seen ? lat : 999), 128'(4));
        check("midrst_first_s", 128'(bus0.s), 128'(64'd30));
        @(negedge clk);
        check("midrst_drained", 128'(bus0.out_valid), 128'(0));

        // Parameter sweeps.
        sweep_go = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (sweep_done_cnt == 4) break;
        end
        check("sweep_all_done", 128'(sweep_done_cnt), 128'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the flat 64-bit ripple ALU. Same four operations (NOR, XOR, ADD, SUB with carry-in and carry-out) over a configurable `WIDTH`. The carry chain is cut into `STAGES` equal segments with one register stage per segment, and operands and results move under a valid/ready handshake. The block adds status flags (zero, negative, signed overflow) and sits between the operand-issue logic and the result writeback.

## Interface
Parameters:
- `WIDTH`, 64: operand/result width; ≥2.
- `STAGES`, 4: pipeline segments; ≥1, `WIDTH % STAGES == 0`; violation → elaboration error. Segment width `SEG = WIDTH/STAGES`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat.
- `a`, `b` in WIDTH: operands.
- `cin` in 1: carry-in to bit 0.
- `op` in 2: operation, `alu_op_t`.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: downstream accepts the result.
- `s` out WIDTH: result.
- `cout` out 1: carry out of the MSB.
- `zero`, `neg`, `ovf` out 1: result == 0; `s[WIDTH-1]`; signed overflow.

## Operation
- Op encoding: 0 NOR (`~(a|b)`), 1 XOR (`a^b`), 2 ADD (`a+b+cin`), 3 SUB (`a+~b+cin`). The caller drives `cin=1` for a true `a-b`.
- Arithmetic is modulo 2^WIDTH. `cout` is the carry out of bit WIDTH-1 for ADD/SUB. `cout` is 0 for NOR/XOR.
- `ovf` for ADD: `a[msb]==b[msb] && s[msb]!=a[msb]`.
- `ovf` for SUB: `a[msb]!=b[msb] && s[msb]!=a[msb]`.
- `ovf` is 0 for NOR/XOR. `zero` and `neg` apply to every op.
- Segment k (bits `k*SEG .. k*SEG+SEG-1`) is computed in stage k. It uses the carry registered from stage k-1; stage 0 uses `cin`.
- Operand slices for later segments travel through skew registers. Lower result slices are held in de-skew registers so all WIDTH bits emerge together.
- Each stage holds a valid bit, an op field, a partial carry, and the data slices.
- Stall rule: global stall `stall = out_valid && !out_ready`.
  - While stalled, every stage register holds.
  - `in_ready = !rst && !stall`.
  - Bubbles are not compressed.
- Accept a beat when `in_valid && in_ready` on a rising edge.
- Results leave in issue order; no beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge t appears on `out_valid`/`s` after edge t+STAGES-1. It is visible in the cycle following that edge, i.e. STAGES cycles after acceptance, with no stalls.
- Throughput: 1 beat/cycle when `out_ready` stays high.
- Outputs are registered. Flags are computed in the final stage and aligned with `s`.
- `in_ready` is combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid`, `a`, or `b` to any output.
- Reset values (cycle after `rst` sampled high):
  - All stage valids = 0 and `out_valid` = 0.
  - `s` = 0, `cout`/`zero`/`neg`/`ovf` = 0.
  - `in_ready` = 0 while `rst` is high.
- Reset mid-operation: in-flight beats are discarded. No stale result appears after `rst` deasserts. The first accept is possible at the first edge with `rst` low.
- Simultaneous accept and output handshake in one cycle: both complete, and the pipeline advances.
- `out_ready` may be high while `out_valid` is low; it is ignored.
- `STAGES=1`: single register stage, latency 1, full-width ripple in one cycle.

## Structure
- Shared package `alu_pkg`:
  - `typedef enum logic [1:0] alu_op_t {OP_NOR, OP_XOR, OP_ADD, OP_SUB}`.
  - Function `is_arith(op)`.
- Sub-module `alu_seg`: combinational SEG-bit slice (inputs a, b, cin, op → s, cout). It is a chain of the existing `alu1bit` cells and is instantiated once per stage via generate.
- The top holds the stage/skew registers, valid/stall logic, and flag generation.

## Test plan
Run with WIDTH=64, STAGES=4 unless noted.
- ADD `a=0xFFFF_FFFF_FFFF_FFFF`, `b=1`, `cin=0` → after 4 cycles `s=0`, `cout=1`, `zero=1`, `neg=0`, `ovf=0` (carry crosses all segments).
- SUB `a=5`, `b=7`, `cin=1` → `s=0xFFFF_FFFF_FFFF_FFFE`, `cout=0`, `neg=1`, `ovf=0`. ADD `a=0x7FFF_FFFF_FFFF_FFFF`, `b=1` → `s=0x8000_0000_0000_0000`, `ovf=1`, `neg=1`.
- NOR `a=b=0` → `s` all ones, `cout=0`, `neg=1`. XOR `a=b=0x1234` → `s=0`, `zero=1`.
- Backpressure: 10 back-to-back random beats with `out_ready` low for cycles 6–8.
  - `in_ready` is low exactly while `out_valid && !out_ready`.
  - All 10 results are correct, in order, with no duplicates.
- Reset mid-stream: assert `rst` for one cycle with 3 beats in flight → `out_valid=0` next cycle and zero outputs. The first output after release comes from a post-reset beat.
- Sweep with reference model: STAGES ∈ {1, 2, 8} and WIDTH=16/STAGES=4, 1000 random beats each → every result matches, and latency equals STAGES.
